// File: rtl/seg7_pkg.sv
// rtl/seg7_pkg.sv - segment glyph constants and capture FSM state type
package seg7_pkg;

  localparam int SEG_W = 7;

  localparam logic [SEG_W-1:0] SEG_0     = 7'h40;
  localparam logic [SEG_W-1:0] SEG_1     = 7'h79;
  localparam logic [SEG_W-1:0] SEG_2     = 7'h24;
  localparam logic [SEG_W-1:0] SEG_3     = 7'h30;
  localparam logic [SEG_W-1:0] SEG_4     = 7'h19;
  localparam logic [SEG_W-1:0] SEG_5     = 7'h12;
  localparam logic [SEG_W-1:0] SEG_6     = 7'h02;
  localparam logic [SEG_W-1:0] SEG_7     = 7'h78;
  localparam logic [SEG_W-1:0] SEG_8     = 7'h00;
  localparam logic [SEG_W-1:0] SEG_9     = 7'h18;
  localparam logic [SEG_W-1:0] SEG_BLANK = 7'h7F;
  localparam logic [SEG_W-1:0] SEG_A     = 7'h08;
  localparam logic [SEG_W-1:0] SEG_B     = 7'h03;
  localparam logic [SEG_W-1:0] SEG_C     = 7'h46;
  localparam logic [SEG_W-1:0] SEG_D     = 7'h21;
  localparam logic [SEG_W-1:0] SEG_E     = 7'h06;
  localparam logic [SEG_W-1:0] SEG_F     = 7'h0E;

  typedef enum logic {
    CAP_IDLE    = 1'b0,
    CAP_PENDING = 1'b1
  } capture_state_t;

endpackage

// File: rtl/seg7_pattern_lut.sv
// rtl/seg7_pattern_lut.sv - active-low segment pattern to nibble decode
// SEG7_CAPTURE_HEX_EN enables the A..F glyphs; otherwise they decode as errors.
module seg7_pattern_lut
  import seg7_pkg::*;
(
  input  logic [SEG_W-1:0] seg,
  output logic             err,
  output logic [3:0]       nibble
);

  always_comb begin
    err    = 1'b0;
    nibble = 4'hF;
    case (seg)
      SEG_0: nibble = 4'h0;
      SEG_1: nibble = 4'h1;
      SEG_2: nibble = 4'h2;
      SEG_3: nibble = 4'h3;
      SEG_4: nibble = 4'h4;
      SEG_5: nibble = 4'h5;
      SEG_6: nibble = 4'h6;
      SEG_7: nibble = 4'h7;
      SEG_8: nibble = 4'h8;
      SEG_9: nibble = 4'h9;
`ifdef SEG7_CAPTURE_HEX_EN
      SEG_A: nibble = 4'hA;
      SEG_B: nibble = 4'hB;
      SEG_C: nibble = 4'hC;
      SEG_D: nibble = 4'hD;
      SEG_E: nibble = 4'hE;
      SEG_F: nibble = 4'hF;
`endif
      default: err = 1'b1;
    endcase
  end

endmodule

// File: rtl/seg7_capture_decoder.sv
// rtl/seg7_capture_decoder.sv - settle filter, duplicate suppression and report handshake
// Hex glyph decode is selected by SEG7_CAPTURE_HEX_EN inside seg7_pattern_lut.
module seg7_capture_decoder
  import seg7_pkg::*;
#(
  parameter int STABLE_CYCLES = 4,
  parameter int CNT_W         = $clog2(STABLE_CYCLES + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_ena,
  input  logic [SEG_W-1:0] seg_in,
  output logic [3:0]       digit_out,
  output logic             digit_err,
  output logic             digit_valid,
  input  logic             out_ready,
  output logic             overrun
);

  localparam logic [CNT_W-1:0] RUN_SAT  = CNT_W'(STABLE_CYCLES);
  localparam logic [CNT_W-1:0] RUN_LAST = CNT_W'(STABLE_CYCLES - 1);

  logic [SEG_W-1:0] seg_q;
  logic [SEG_W-1:0] last_pat, last_pat_d;
  logic [CNT_W-1:0] run_cnt;
  capture_state_t   state, state_d;
  logic [3:0]       digit_out_d;
  logic             digit_err_d, digit_valid_d, overrun_d;
  logic             lut_err;
  logic [3:0]       lut_nibble;
  logic             same, settle, reportable, accept;

  seg7_pattern_lut u_lut (
    .seg    (seg_in),
    .err    (lut_err),
    .nibble (lut_nibble)
  );

  // The counter saturates, so the settle event fires only once per run.
  assign same       = (seg_in == seg_q);
  assign settle     = i_ena && same && (run_cnt == RUN_LAST);
  assign reportable = settle && (seg_in != SEG_BLANK) && (seg_in != last_pat);
  assign accept     = digit_valid && out_ready;

  always_comb begin
    state_d       = state;
    digit_out_d   = digit_out;
    digit_err_d   = digit_err;
    digit_valid_d = digit_valid;
    overrun_d     = overrun;
    last_pat_d    = last_pat;
    if (settle && (seg_in == SEG_BLANK))
      last_pat_d = SEG_BLANK;
    case (state)
      CAP_IDLE: begin
        if (reportable) begin
          digit_out_d   = lut_nibble;
          digit_err_d   = lut_err;
          digit_valid_d = 1'b1;
          last_pat_d    = seg_in;
          state_d       = CAP_PENDING;
        end
      end
      CAP_PENDING: begin
        if (accept) begin
          if (reportable) begin
            digit_out_d = lut_nibble;
            digit_err_d = lut_err;
            last_pat_d  = seg_in;
          end else begin
            digit_valid_d = 1'b0;
            state_d       = CAP_IDLE;
          end
        end else if (reportable) begin
          overrun_d = 1'b1;
        end
      end
      default: state_d = CAP_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      seg_q       <= SEG_BLANK;
      run_cnt     <= '0;
      last_pat    <= SEG_BLANK;
      state       <= CAP_IDLE;
      digit_out   <= 4'h0;
      digit_err   <= 1'b0;
      digit_valid <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      seg_q <= seg_in;
      if (!i_ena || !same)
        run_cnt <= '0;
      else if (run_cnt != RUN_SAT)
        run_cnt <= run_cnt + 1'b1;
      last_pat    <= last_pat_d;
      state       <= state_d;
      digit_out   <= digit_out_d;
      digit_err   <= digit_err_d;
      digit_valid <= digit_valid_d;
      overrun     <= overrun_d;
    end
  end

endmodule

// File: tb/tb_seg7_capture_decoder.sv
// tb/tb_seg7_capture_decoder.sv - directed bench for seg7_capture_decoder
// Expected A..F behaviour follows SEG7_CAPTURE_HEX_EN.
module tb_seg7_capture_decoder;

  logic       clk = 1'b0;
  logic       rst;
  logic       i_ena;
  logic [6:0] seg_in;
  logic [3:0] digit_out;
  logic       digit_err;
  logic       digit_valid;
  logic       out_ready;
  logic       overrun;

  int checks = 0;
  int errors = 0;
  int acc_cnt = 0;
  int acc_digit = -1;
  int base;

  seg7_capture_decoder #(.STABLE_CYCLES(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .i_ena       (i_ena),
    .seg_in      (seg_in),
    .digit_out   (digit_out),
    .digit_err   (digit_err),
    .digit_valid (digit_valid),
    .out_ready   (out_ready),
    .overrun     (overrun)
  );

  always #5 clk = ~clk;

  // Inputs change just after posedge, so negedge sees what the next edge will accept.
  always @(negedge clk) begin
    if (!rst && digit_valid && out_ready) begin
      acc_cnt   <= acc_cnt + 1;
      acc_digit <= int'(digit_out);
    end
  end

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic hold(input logic [6:0] p, input int n);
    seg_in = p;
    step(n);
  endtask

  initial begin
    rst = 1'b1; i_ena = 1'b0; seg_in = 7'h7F; out_ready = 1'b1;
    step(2);
    check("rst_valid", digit_valid, 0);
    check("rst_digit", digit_out, 0);
    check("rst_err", digit_err, 0);
    check("rst_overrun", overrun, 0);

    // Latency: held pattern appears valid in cycle 5 for one cycle.
    rst = 1'b0; i_ena = 1'b1; seg_in = 7'h24;
    for (int k = 1; k <= 6; k++) begin
      step(1);
      if (k == 4) check("lat_c4_valid", digit_valid, 0);
      if (k == 5) begin
        check("lat_c5_valid", digit_valid, 1);
        check("lat_c5_digit", digit_out, 2);
        check("lat_c5_err", digit_err, 0);
      end
      if (k == 6) check("lat_c6_valid", digit_valid, 0);
    end
    check("lat_count", acc_cnt, 1);

    // Toggling every 2 cycles never settles.
    base = acc_cnt;
    for (int i = 0; i < 6; i++) hold((i % 2) ? 7'h30 : 7'h24, 2);
    check("tog_none", acc_cnt - base, 0);
    hold(7'h30, 8);
    check("tog_one", acc_cnt - base, 1);
    check("tog_digit", acc_digit, 3);

    // A blank between equal digits re-arms the duplicate filter.
    base = acc_cnt;
    hold(7'h79, 8);
    hold(7'h79, 4);
    check("dup_first", acc_cnt - base, 1);
    hold(7'h7F, 8);
    check("dup_blank", acc_cnt - base, 1);
    hold(7'h79, 8);
    check("dup_second", acc_cnt - base, 2);
    check("dup_digit", acc_digit, 1);

    // Overrun: second settle while pending is dropped.
    out_ready = 1'b0;
    hold(7'h19, 8);
    check("ovr_valid", digit_valid, 1);
    check("ovr_digit4", digit_out, 4);
    check("ovr_flag_pre", overrun, 0);
    hold(7'h12, 8);
    check("ovr_digit_frozen", digit_out, 4);
    check("ovr_flag", overrun, 1);
    base = acc_cnt;
    out_ready = 1'b1;
    step(4);
    check("ovr_accept_cnt", acc_cnt - base, 1);
    check("ovr_accept_digit", acc_digit, 4);
    check("ovr_idle", digit_valid, 0);
    check("ovr_sticky", overrun, 1);

    // Hex glyph A.
    out_ready = 1'b0;
    hold(7'h08, 8);
    check("hex_valid", digit_valid, 1);
`ifdef SEG7_CAPTURE_HEX_EN
    check("hex_digit", digit_out, 10);
    check("hex_err", digit_err, 0);
`else
    check("hex_digit", digit_out, 15);
    check("hex_err", digit_err, 1);
`endif

    // Reset while pending with overrun set, then the same pattern reports afresh.
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    check("rst2_valid", digit_valid, 0);
    check("rst2_overrun", overrun, 0);
    check("rst2_digit", digit_out, 0);
    step(6);
    check("rst2_fresh_valid", digit_valid, 1);
`ifdef SEG7_CAPTURE_HEX_EN
    check("rst2_fresh_digit", digit_out, 10);
`else
    check("rst2_fresh_digit", digit_out, 15);
`endif

    // Disabling capture keeps the pending report.
    i_ena = 1'b0;
    hold(7'h40, 6);
    check("ena_keep_valid", digit_valid, 1);
    out_ready = 1'b1;
    step(2);
    check("ena_drained", digit_valid, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
